// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, device-clocked
// 11-bit frame, then the device ACK. Drives the open-drain pair through enables only.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | lines released, waiting for tx_start
// INHIBIT   | PS2Clk held low; start bit driven on the last cycle
// RTS       | release PS2Clk, keep data low, wait for device to clock
// SEND      | shift data bits, parity and stop out on device falling edges
// ACK       | sample the device ACK on the 11th falling edge
// WAIT_IDLE | wait for both lines to return high
// DONE      | one-cycle done pulse with result flags
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout,
  output logic       rx_inhibit,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic       ps2_clk_low,
  output logic       ps2_data_low
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       clk_sync, data_sync;
  logic             clk_s, data_s;
  logic             clk_filt;
  logic [FLT_W-1:0] flt_cnt;
  logic             fall;

  logic [9:0]       sh;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic clk_low_d, data_low_d;
  logic accept, shift, ack_upd, tmo_set;
  logic inh_tc, tmo_tc, tmo_load;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Two-flop synchronisers; idle bus level is high so reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], PS2Clk};
      data_sync <= {data_sync[0], PS2Data};
    end
  end

  // PS2Clk level filter; fall pulses in the cycle the filtered level drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s != clk_filt) begin
        if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
          clk_filt <= clk_s;
          flt_cnt  <= '0;
          fall     <= clk_filt;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign inh_tc   = (inh_cnt == '0);
  // A device edge in the same cycle as expiry counts as activity
  assign tmo_tc   = (tmo_cnt == '0) && !fall;
  assign tmo_load = ((state_q == INHIBIT) && inh_tc) || fall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and next line-enable values
  always_comb begin
    state_d    = state_q;
    clk_low_d  = ps2_clk_low;
    data_low_d = ps2_data_low;
    accept     = 1'b0;
    shift      = 1'b0;
    ack_upd    = 1'b0;
    tmo_set    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          accept     = 1'b1;
          state_d    = INHIBIT;
          clk_low_d  = 1'b1;
          data_low_d = (INHIBIT_CYCLES <= 1);
        end
      end
      INHIBIT: begin
        clk_low_d  = 1'b1;
        data_low_d = (inh_cnt <= INH_W'(1));
        if (inh_tc) state_d = RTS;
      end
      RTS: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (fall) begin
          data_low_d = ~sh[0];
          shift      = 1'b1;
          if (bit_cnt == 4'd9) state_d = ACK;
        end
      end
      ACK: begin
        if (fall) begin
          ack_upd = 1'b1;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_filt && data_s) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if ((state_q == RTS || state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) && tmo_tc) begin
      state_d    = DONE;
      clk_low_d  = 1'b0;
      data_low_d = 1'b0;
      shift      = 1'b0;
      ack_upd    = 1'b0;
      tmo_set    = 1'b1;
    end
  end

  // Frame shifter, down-counters, result flags and registered line enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps2_clk_low  <= 1'b0;
      ps2_data_low <= 1'b0;
      sh           <= '0;
      bit_cnt      <= '0;
      inh_cnt      <= '0;
      tmo_cnt      <= '0;
      ack_err      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      ps2_clk_low  <= clk_low_d;
      ps2_data_low <= data_low_d;
      if (accept) begin
        sh      <= {1'b1, ~^tx_data, tx_data};
        bit_cnt <= '0;
        inh_cnt <= INH_W'(INHIBIT_CYCLES - 1);
        ack_err <= 1'b0;
        timeout <= 1'b0;
      end else begin
        if ((state_q == INHIBIT) && !inh_tc) inh_cnt <= inh_cnt - 1'b1;
        if (shift) begin
          sh      <= {1'b0, sh[9:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (tmo_load)           tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
      else if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
      if (ack_upd) ack_err <= data_s;
      if (tmo_set) begin
        timeout <= 1'b1;
        ack_err <= 1'b0;
      end
    end
  end

  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = (state_q == DONE);
  assign rx_inhibit = busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a simple device model.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int TMO  = 400;
  localparam int FLT  = 4;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, done, ack_err, timeout, rx_inhibit;
  logic       ps2_clk_low, ps2_data_low;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2clk_line, ps2data_line;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int clk_run = 0;
  int last_clk_run = 0;
  logic start_at_release = 1'b0;

  assign ps2clk_line  = ~(ps2_clk_low | dev_clk_low);
  assign ps2data_line = ~(ps2_data_low | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(FLT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .busy(busy),
    .done(done),
    .ack_err(ack_err),
    .timeout(timeout),
    .rx_inhibit(rx_inhibit),
    .PS2Clk(ps2clk_line),
    .PS2Data(ps2data_line),
    .ps2_clk_low(ps2_clk_low),
    .ps2_data_low(ps2_data_low)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Length of each host clock-inhibit pulse and the data state when it ends
  always @(negedge clk) begin
    if (ps2_clk_low) clk_run = clk_run + 1;
    else if (clk_run != 0) begin
      last_clk_run     = clk_run;
      clk_run          = 0;
      start_at_release = ps2_data_low;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_start(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = ~d;
    chk("busy_after_start", {busy, rx_inhibit}, 2'b11);
  endtask

  // Device: waits for RTS, generates nclk clocks, samples data before each rise
  task automatic dev_run(input int nclk, input bit do_ack, input bit glitch, output logic [9:0] got);
    int n;
    got = '0;
    n = 0;
    while (!(ps2clk_line === 1'b1 && ps2data_line === 1'b0) && n < INH + 500) begin
      @(negedge clk);
      n++;
    end
    chk("rts_seen", 32'(n < INH + 500), 1);
    if (n >= INH + 500) return;
    repeat (20) @(negedge clk);
    for (int i = 1; i <= nclk; i++) begin
      if (i == 11 && do_ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      last_fall_cyc = cyc;
      if (glitch) begin
        repeat (8) @(negedge clk);
        dev_clk_low = 1'b0;
        @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF - 9) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (i <= 10) got[i-1] = ps2data_line;
      dev_clk_low = 1'b0;
      if (glitch) begin
        repeat (6) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (1 + (i % 2)) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF - 7 - (i % 2)) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (i == 11) dev_data_low = 1'b0;
    end
  endtask

  // flags = {ack_err, timeout, any line driven, busy} on the done cycle
  task automatic wait_done(input int budget, output int dcyc, output logic [3:0] flags);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    dcyc = 0;
    flags = 4'hF;
    while (n < budget && !seen) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        seen  = 1;
        dcyc  = cyc;
        flags = {ack_err, timeout, ps2_clk_low | ps2_data_low, busy};
      end
    end
    chk("done_seen", 32'(seen), 1);
    if (seen) begin
      @(negedge clk);
      chk("done_pulse", {done, busy}, 2'b00);
    end
  endtask

  task automatic xfer(input logic [7:0] d, input int nclk, input bit do_ack, input bit glitch,
                      input bit mid, output logic [9:0] got, output int dcyc, output logic [3:0] flags);
    send_start(d);
    fork
      dev_run(nclk, do_ack, glitch, got);
      wait_done(3000, dcyc, flags);
      begin
        if (mid) begin
          repeat (INH + 100) @(negedge clk);
          tx_data  = 8'h55;
          tx_start = 1'b1;
          @(negedge clk);
          tx_start = 1'b0;
        end
      end
    join
  endtask

  logic [9:0] got;
  int         dcyc;
  logic [3:0] flags;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", {busy, done, ack_err, timeout, rx_inhibit, ps2_clk_low, ps2_data_low}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED with ACK: frame {stop, par, data} = 3ED
    xfer(8'hED, 11, 1, 0, 0, got, dcyc, flags);
    chk("ed_frame", got, 10'h3ED);
    chk("ed_flags", flags, 4'b0000);
    chk("inhibit_len", last_clk_run, INH + 1);
    chk("start_bit", start_at_release, 1'b1);

    // parity cases
    xfer(8'hF4, 11, 1, 0, 0, got, dcyc, flags);
    chk("f4_frame", got, 10'h2F4);
    chk("f4_flags", flags, 4'b0000);
    xfer(8'h00, 11, 1, 0, 1, got, dcyc, flags);
    chk("00_frame_mid_start", got, 10'h300);
    chk("00_flags", flags, 4'b0000);
    repeat (100) @(negedge clk);
    chk("no_queue", {busy, ps2_clk_low, ps2_data_low}, 3'b000);
    xfer(8'hFF, 11, 1, 0, 0, got, dcyc, flags);
    chk("ff_frame", got, 10'h3FF);
    chk("ff_flags", flags, 4'b0000);

    // missing ACK
    xfer(8'hED, 11, 0, 0, 0, got, dcyc, flags);
    chk("noack_frame", got, 10'h3ED);
    chk("noack_flags", flags, 4'b1000);
    repeat (50) @(negedge clk);
    chk("ack_err_hold", {ack_err, timeout}, 2'b10);

    // device stops after fall 5
    send_start(8'hF4);
    chk("flags_clear", {ack_err, timeout}, 2'b00);
    fork
      dev_run(5, 0, 0, got);
      wait_done(3000, dcyc, flags);
    join
    chk("tmo_flags", flags, 4'b0100);
    // raw edge -> 2 sync + FLT filter + counter load, TMO count, state register
    chk("tmo_latency", dcyc - last_fall_cyc, TMO + FLT + 4);
    chk("tmo_released", {ps2_clk_low, ps2_data_low}, 2'b00);

    // glitchy device clock
    xfer(8'hED, 11, 1, 1, 0, got, dcyc, flags);
    chk("glitch_frame", got, 10'h3ED);
    chk("glitch_flags", flags, 4'b0000);

    // async reset during INHIBIT
    send_start(8'h00);
    repeat (10) @(negedge clk);
    chk("inhibit_clk_low", ps2_clk_low, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("rst_inh_lines", {ps2_clk_low, ps2_data_low, busy}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // async reset during SEND (bit 3 of 0x00 keeps data driven)
    send_start(8'h00);
    dev_run(4, 0, 0, got);
    chk("pre_rst_data_low", {ps2_data_low, busy}, 2'b11);
    #1 rst_n = 1'b0;
    #1 chk("rst_send_lines", {ps2_clk_low, ps2_data_low, busy, done}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    xfer(8'hA5, 11, 1, 0, 0, got, dcyc, flags);
    chk("a5_after_rst_frame", got, 10'h3A5);
    chk("a5_flags", flags, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
